// File: rtl/iserdes_freq_gen_if.sv
// Control and serializer-word bundle for the sub-tick square-wave generator.
// master drives the controls, slave is the generator.
interface iserdes_freq_gen_if #(
  parameter int COUNTER_BITS = 16
);
  logic                    enable;
  logic [COUNTER_BITS-1:0] half_period;
  logic                    half_period_wr;
  logic [7:0]              oserdes_data;
  logic                    edge_flag;
  logic [2:0]              edge_pos;
  logic                    edge_rising;

  modport master (
    output enable, half_period, half_period_wr,
    input  oserdes_data, edge_flag, edge_pos, edge_rising
  );

  modport slave (
    input  enable, half_period, half_period_wr,
    output oserdes_data, edge_flag, edge_pos, edge_rising
  );
endinterface

// File: rtl/iserdes_freq_gen.sv
// Square-wave generator with 1/8-clock edge resolution feeding an 8:1 OSERDES.
// One word per clock, bit 0 earliest; half-period programmed in sub-ticks.
module iserdes_freq_gen #(
  parameter int COUNTER_BITS = 16,
  parameter int MIN_HALF     = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  iserdes_freq_gen_if.slave  gen
);
  localparam int CW = COUNTER_BITS;
  localparam logic [CW-1:0] MIN_H = CW'(MIN_HALF);
  localparam logic [CW-1:0] WORD  = CW'(8);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]    state, state_d;
  logic          lvl, lvl_d;
  logic [CW-1:0] rem, rem_d;
  logic [CW-1:0] hpend;

  logic [CW-1:0] h_next, h_eff;
  logic          near;
  logic [7:0]    low_mask;

  logic [7:0]    word_d;
  logic          flag_d;
  logic [2:0]    pos_d;
  logic          rise_d;

  logic [7:0]    word_q;
  logic          flag_q;
  logic [2:0]    pos_q;
  logic          rise_q;

  // A same-cycle write is visible to both start and reload.
  assign h_next   = gen.half_period_wr ? gen.half_period : hpend;
  assign h_eff    = (h_next < MIN_H) ? MIN_H : h_next;
  assign near     = (rem < WORD);
  assign low_mask = ~(8'hFF << rem[2:0]);

  always_comb begin
    state_d = state;
    lvl_d   = lvl;
    rem_d   = rem;
    word_d  = 8'h00;
    flag_d  = 1'b0;
    pos_d   = 3'd0;
    rise_d  = 1'b0;
    unique case (1'b1)
      !gen.enable: begin
        state_d = ST_IDLE;
        lvl_d   = 1'b0;
      end
      gen.enable && (state == ST_IDLE): begin
        state_d = ST_RUN;
        lvl_d   = 1'b0;
        rem_d   = h_eff;
      end
      gen.enable && (state == ST_RUN) && !near: begin
        word_d = {8{lvl}};
        rem_d  = rem - WORD;
      end
      gen.enable && (state == ST_RUN) && near: begin
        word_d = lvl ? low_mask : ~low_mask;
        flag_d = 1'b1;
        pos_d  = rem[2:0];
        rise_d = ~lvl;
        lvl_d  = ~lvl;
        rem_d  = rem + h_eff - WORD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= ST_IDLE;
      lvl    <= 1'b0;
      rem    <= '0;
      hpend  <= MIN_H;
      word_q <= 8'h00;
      flag_q <= 1'b0;
      pos_q  <= 3'd0;
      rise_q <= 1'b0;
    end else begin
      state  <= state_d;
      lvl    <= lvl_d;
      rem    <= rem_d;
      if (gen.half_period_wr)
        hpend <= gen.half_period;
      word_q <= word_d;
      flag_q <= flag_d;
      pos_q  <= pos_d;
      rise_q <= rise_d;
    end
  end

  assign gen.oserdes_data = word_q;
  assign gen.edge_flag    = flag_q;
  assign gen.edge_pos     = pos_q;
  assign gen.edge_rising  = rise_q;
endmodule

// File: tb/tb_iserdes_freq_gen.sv
// Bench for iserdes_freq_gen: literal vector table, then a sub-tick
// reference model feeding a scoreboard, plus edge-distance checks.
module tb_iserdes_freq_gen;
  typedef struct packed {
    logic [7:0] d;
    logic       f;
    logic [2:0] p;
    logic       r;
  } out_t;

  typedef struct {
    bit          en;
    bit          wr;
    logic [15:0] hp;
    out_t        exp;
  } vec_t;

  logic clk;
  logic rst;

  iserdes_freq_gen_if #(.COUNTER_BITS(16)) gen ();

  iserdes_freq_gen #(
    .COUNTER_BITS(16),
    .MIN_HALF(8)
  ) dut (
    .CLK(clk),
    .RESET(rst),
    .gen(gen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     n_checks;
  int     n_fail;
  longint cyc_no;
  longint edges[$];
  out_t   sbq[$];
  vec_t   vq[$];

  bit m_run;
  bit m_lvl;
  int m_cnt;
  int m_h;

  task automatic check(input string name, input out_t a, input out_t e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got d=%h f=%b p=%0d r=%b, expected d=%h f=%b p=%0d r=%b",
               name, a.d, a.f, a.p, a.r, e.d, e.f, e.p, e.r);
    end
  endtask

  task automatic chk_int(input string name, input longint a, input longint e);
    n_checks++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, a, e);
    end
  endtask

  function automatic out_t dut_out();
    return {gen.oserdes_data, gen.edge_flag, gen.edge_pos, gen.edge_rising};
  endfunction

  function automatic void model_reset();
    m_run = 1'b0;
    m_lvl = 1'b0;
    m_cnt = 0;
    m_h   = 8;
  endfunction

  // Walks the eight sub-ticks of one word, toggling when the count expires.
  function automatic out_t model_step(bit en, bit wr, int hp);
    out_t o;
    int   eff;
    o = '0;
    if (wr) m_h = hp;
    eff = (m_h < 8) ? 8 : m_h;
    if (!en) begin
      m_run = 1'b0;
      m_lvl = 1'b0;
    end else if (!m_run) begin
      m_run = 1'b1;
      m_lvl = 1'b0;
      m_cnt = eff;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (m_cnt == 0) begin
          m_lvl = ~m_lvl;
          m_cnt = eff;
          o.f   = 1'b1;
          o.p   = i[2:0];
          o.r   = m_lvl;
        end
        o.d[i] = m_lvl;
        m_cnt--;
      end
    end
    return o;
  endfunction

  task automatic cyc(input bit en, input bit wr, input logic [15:0] hp);
    out_t a;
    out_t e;
    gen.enable         = en;
    gen.half_period_wr = wr;
    gen.half_period    = hp;
    sbq.push_back(model_step(en, wr, int'(hp)));
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    a = dut_out();
    check("sb", a, e);
    if (a.f) edges.push_back(cyc_no * 8 + longint'(a.p));
    cyc_no++;
    gen.half_period_wr = 1'b0;
  endtask

  task automatic do_reset();
    gen.enable         = 1'b0;
    gen.half_period_wr = 1'b0;
    gen.half_period    = 16'd0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset_out", dut_out(), '0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    sbq.delete();
    edges.delete();
  endtask

  task automatic row(input bit en, input bit wr, input logic [15:0] hp,
                     input logic [7:0] d, input bit f, input logic [2:0] p,
                     input bit r);
    vec_t v;
    v.en  = en;
    v.wr  = wr;
    v.hp  = hp;
    v.exp = {d, f, p, r};
    vq.push_back(v);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc_no   = 0;
    rst      = 1'b0;
    model_reset();

    // H=8, then drop ENABLE while high
    row(0, 1, 16'd8,  8'h00, 0, 3'd0, 0);
    row(1, 0, 16'd0,  8'h00, 0, 3'd0, 0);
    row(1, 0, 16'd0,  8'h00, 0, 3'd0, 0);
    row(1, 0, 16'd0,  8'hFF, 1, 3'd0, 1);
    row(1, 0, 16'd0,  8'h00, 1, 3'd0, 0);
    row(1, 0, 16'd0,  8'hFF, 1, 3'd0, 1);
    row(0, 0, 16'd0,  8'h00, 0, 3'd0, 0);
    // H=12 written on the start cycle
    row(1, 1, 16'd12, 8'h00, 0, 3'd0, 0);
    row(1, 0, 16'd0,  8'h00, 0, 3'd0, 0);
    row(1, 0, 16'd0,  8'hF0, 1, 3'd4, 1);
    row(1, 0, 16'd0,  8'hFF, 0, 3'd0, 0);
    row(1, 0, 16'd0,  8'h00, 1, 3'd0, 0);
    row(1, 0, 16'd0,  8'hF0, 1, 3'd4, 1);
    row(1, 0, 16'd0,  8'hFF, 0, 3'd0, 0);
    row(0, 0, 16'd0,  8'h00, 0, 3'd0, 0);
    // H=3 clamps to 8
    row(1, 1, 16'd3,  8'h00, 0, 3'd0, 0);
    row(1, 0, 16'd0,  8'h00, 0, 3'd0, 0);
    row(1, 0, 16'd0,  8'hFF, 1, 3'd0, 1);
    row(1, 0, 16'd0,  8'h00, 1, 3'd0, 0);
    row(0, 0, 16'd0,  8'h00, 0, 3'd0, 0);

    do_reset();
    foreach (vq[i]) begin
      gen.enable         = vq[i].en;
      gen.half_period_wr = vq[i].wr;
      gen.half_period    = vq[i].hp;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), dut_out(), vq[i].exp);
    end

    // H=20 with a mid-half rewrite to 8
    do_reset();
    cyc(0, 0, 16'd0);
    cyc(1, 1, 16'd20);
    for (int k = 0; k < 20 && edges.size() < 2; k++) cyc(1, 0, 16'd0);
    cyc(1, 1, 16'd8);
    repeat (10) cyc(1, 0, 16'd0);
    chk_int("h20_edges", longint'(edges.size() >= 5), 1);
    if (edges.size() >= 5) begin
      chk_int("h20_d0", edges[1] - edges[0], 20);
      chk_int("h20_d1", edges[2] - edges[1], 20);
      chk_int("h8_d2",  edges[3] - edges[2], 8);
      chk_int("h8_d3",  edges[4] - edges[3], 8);
    end

    // Random enables and writes, including writes on toggle cycles
    do_reset();
    for (int k = 0; k < 300; k++) begin
      cyc($urandom_range(0, 19) != 0, $urandom_range(0, 4) == 0,
          16'($urandom_range(0, 40)));
    end

    // Long half-period as seen by a period-measuring receiver
    do_reset();
    cyc(1, 1, 16'd41159);
    for (int k = 0; k < 20000 && edges.size() < 3; k++) cyc(1, 0, 16'd0);
    chk_int("long_edges", longint'(edges.size() >= 3), 1);
    if (edges.size() >= 3) begin
      chk_int("long_d0", edges[1] - edges[0], 41159);
      chk_int("long_d1", edges[2] - edges[1], 41159);
    end

    // Asynchronous reset mid-run clears outputs before the next edge
    do_reset();
    cyc(1, 1, 16'd12);
    for (int k = 0; k < 8; k++) cyc(1, 0, 16'd0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", dut_out(), '0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    sbq.delete();
    cyc(1, 0, 16'd0);
    cyc(1, 0, 16'd0);
    for (int k = 0; k < 6; k++) cyc(1, 0, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
